// File: rtl/debug_prog_loader.sv
// debug_prog_loader: UART byte stream -> LOAD_PROG decode -> instruction-memory writes with ACK/NAK reply.
// Optional macro CHECKSUM_EN adds a trailing XOR checksum byte check (CHK state).
`default_nettype none

module debug_prog_loader #(
  parameter int         INST_SZ        = 32,
  parameter int         PC             = 32,
  parameter int         SZ_BYTES       = 1,
  parameter int         MEM_DEPTH      = 32,
  parameter int         BIG_ENDIAN     = 0,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] CMD_LOAD       = 8'hFE,
  parameter logic [7:0] ACK_BYTE       = 8'hAC,
  parameter logic [7:0] NAK_BYTE       = 8'hEE
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx_empty,
  input  logic [7:0]            i_rx_data,
  output logic                  o_rd_uart,
  input  logic                  i_tx_full,
  output logic                  o_wr_uart,
  output logic [7:0]            o_w_data,
  output logic [INST_SZ-1:0]    o_instruction,
  output logic                  o_mem_w,
  output logic [PC-1:0]         o_program_mem_addr,
  output logic [8*SZ_BYTES-1:0] o_prog_sz,
  output logic                  o_load_done,
  output logic                  o_error,
  output logic [2:0]            o_state
);

  localparam int SZW = 8 * SZ_BYTES;
  localparam int WB  = INST_SZ / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SIZE  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t               state;
  logic [3:0]           byte_cnt;
  logic [31:0]          tmo_cnt;
  logic [INST_SZ-1:0]   shreg;
  logic                 resp_ack;
`ifdef CHECKSUM_EN
  logic [7:0]           csum;
`endif

  logic                 pop;
  logic                 counting;
  logic                 timeout_hit;
  logic                 last_word;
  logic [SZW-1:0]       sz_next;
  logic [INST_SZ-1:0]   word_next;

  assign counting  = (state == SIZE) || (state == DATA) || (state == CHK);
  assign o_rd_uart = !i_reset && !i_rx_empty && (counting || state == IDLE);
  assign pop       = o_rd_uart;
  assign o_state   = state;

  // Size field arrives LSB first: shift in from the top so the first byte lands in bits [7:0].
  assign sz_next   = SZW'({i_rx_data, o_prog_sz} >> 8);
  assign word_next = (BIG_ENDIAN != 0) ? INST_SZ'({shreg, i_rx_data})
                                       : INST_SZ'({i_rx_data, shreg} >> 8);

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && counting && !pop &&
                       (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign last_word   = (64'(o_program_mem_addr) + 64'd1) == 64'(o_prog_sz);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state              <= IDLE;
      byte_cnt           <= '0;
      tmo_cnt            <= '0;
      shreg              <= '0;
      resp_ack           <= 1'b0;
      o_wr_uart          <= 1'b0;
      o_w_data           <= '0;
      o_instruction      <= '0;
      o_mem_w            <= 1'b0;
      o_program_mem_addr <= '0;
      o_prog_sz          <= '0;
      o_load_done        <= 1'b0;
      o_error            <= 1'b0;
`ifdef CHECKSUM_EN
      csum               <= '0;
`endif
    end else begin
      o_mem_w   <= 1'b0;
      o_wr_uart <= 1'b0;
      if (pop || !counting) tmo_cnt <= '0;
      else                  tmo_cnt <= tmo_cnt + 32'd1;

      case (state)
        IDLE: begin
          if (pop && i_rx_data == CMD_LOAD) begin
            o_load_done        <= 1'b0;
            o_error            <= 1'b0;
            byte_cnt           <= '0;
            o_program_mem_addr <= '0;
            o_prog_sz          <= '0;
`ifdef CHECKSUM_EN
            csum               <= '0;
`endif
            state              <= SIZE;
          end
        end
        SIZE: begin
          if (timeout_hit) begin
            resp_ack <= 1'b0;
            state    <= RESP;
          end else if (pop) begin
            o_prog_sz <= sz_next;
            if (byte_cnt == 4'(SZ_BYTES - 1)) begin
              byte_cnt <= '0;
              if (sz_next == '0) begin
                resp_ack <= 1'b1;
                state    <= RESP;
              end else if (33'(sz_next) > 33'(MEM_DEPTH)) begin
                resp_ack <= 1'b0;
                state    <= RESP;
              end else begin
                state    <= DATA;
              end
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (timeout_hit) begin
            resp_ack <= 1'b0;
            state    <= RESP;
          end else if (pop) begin
            shreg <= word_next;
`ifdef CHECKSUM_EN
            csum  <= csum ^ i_rx_data;
`endif
            if (byte_cnt == 4'(WB - 1)) begin
              byte_cnt      <= '0;
              o_instruction <= word_next;
              o_mem_w       <= 1'b1;
              state         <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        WRITE: begin
          o_program_mem_addr <= o_program_mem_addr + PC'(1);
          if (last_word) begin
`ifdef CHECKSUM_EN
            state    <= CHK;
`else
            resp_ack <= 1'b1;
            state    <= RESP;
`endif
          end else begin
            state <= DATA;
          end
        end
        CHK: begin
`ifdef CHECKSUM_EN
          if (timeout_hit) begin
            resp_ack <= 1'b0;
            state    <= RESP;
          end else if (pop) begin
            resp_ack <= (i_rx_data == csum);
            state    <= RESP;
          end
`else
          state <= IDLE;
`endif
        end
        RESP: begin
          if (!i_tx_full) begin
            o_wr_uart   <= 1'b1;
            o_w_data    <= resp_ack ? ACK_BYTE : NAK_BYTE;
            o_load_done <= resp_ack;
            o_error     <= !resp_ack;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
